// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: input/output handshake bundle for mix_columns_seq.
// Optional inv bit exists only when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] inp_data;
  logic         bypass;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mixed_data;
  logic         busy;
`ifdef MIX_COLUMNS_INV_EN
  modport master (output in_valid, inp_data, bypass, inv, out_ready,
                  input in_ready, out_valid, mixed_data, busy);
  modport slave  (input in_valid, inp_data, bypass, inv, out_ready,
                  output in_ready, out_valid, mixed_data, busy);
`else
  modport master (output in_valid, inp_data, bypass, out_ready,
                  input in_ready, out_valid, mixed_data, busy);
  modport slave  (input in_valid, inp_data, bypass, out_ready,
                  output in_ready, out_valid, mixed_data, busy);
`endif
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns sequencer (one column per cycle) with final-round bypass.
// Ports: clk, rst_n (sync active-low), bus (slave): in_valid/in_ready/inp_data/bypass in,
// out_valid/out_ready/mixed_data out, busy. MIX_COLUMNS_INV_EN adds bus.inv for InvMixColumns.
module mix_columns_seq (
  input  logic           clk,
  input  logic           rst_n,
  mix_columns_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
  state_t       state;
  logic [1:0]   col;
  logic [127:0] src, res;
  logic         inv_q;
  logic [31:0]  a, mc;
  logic [15:0]  k;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // Multiply by a 4-bit GF(2^8) constant as an XOR of x, 2x, 4x, 8x.
  function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction
  // k holds the first row's coefficients; later rows rotate them right by one byte position.
  always_comb begin
    a  = src[7'd127 - {col, 5'd0} -: 32];
    k  = inv_q ? 16'hebd9 : 16'h2311;
    mc = {gm(a[31:24], k[15:12]) ^ gm(a[23:16], k[11:8])  ^ gm(a[15:8], k[7:4])   ^ gm(a[7:0], k[3:0]),
          gm(a[31:24], k[3:0])   ^ gm(a[23:16], k[15:12]) ^ gm(a[15:8], k[11:8])  ^ gm(a[7:0], k[7:4]),
          gm(a[31:24], k[7:4])   ^ gm(a[23:16], k[3:0])   ^ gm(a[15:8], k[15:12]) ^ gm(a[7:0], k[11:8]),
          gm(a[31:24], k[11:8])  ^ gm(a[23:16], k[7:4])   ^ gm(a[15:8], k[3:0])   ^ gm(a[7:0], k[15:12])};
  end
`ifdef MIX_COLUMNS_INV_EN
  always_ff @(posedge clk)
    if (!rst_n) inv_q <= 1'b0;
    else if (state == IDLE && bus.in_valid) inv_q <= bus.inv;
`else
  assign inv_q = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      col   <= 2'd0;
      src   <= '0;
      res   <= '0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          src   <= bus.inp_data;
          col   <= 2'd0;
          res   <= bus.bypass ? bus.inp_data : res;
          state <= bus.bypass ? DONE : MIX;
        end
        MIX: begin
          res[7'd127 - {col, 5'd0} -: 32] <= mc;
          col   <= col + 2'd1;
          state <= col == 2'd3 ? DONE : MIX;
        end
        DONE: state <= bus.out_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == DONE;
  assign bus.busy       = state != IDLE;
  assign bus.mixed_data = res;
endmodule
